sbox_share_sched: RTL

Time-multiplexed S-box scheduler for the AES-128 core. It owns four SBox lookup instances and shares them between two requesters. The round datapath's 128-bit SubBytes/InvSubBytes is processed 32 bits per cycle. The key-expansion SubWord is a 32-bit, encrypt-direction operation. The block sits between the round controller, the key scheduler and the S-box lookups, and replaces sixteen per-round plus four key S-box instances with four.

---
 rtl/sbox_share_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sbox_share_sched.sv
// rtl/sbox_share_sched.sv - four shared AES S-boxes time-multiplexed between state and key requesters
// The S-box is computed as GF(2^8) inversion plus affine maps rather than stored as a table.

module sbox_lookup (
  input  logic [7:0] data,
  input  logic       dec,
  output logic [7:0] result
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  always_comb begin
    pre    = dec ? aff_inv(data) : data;
    inv    = gf_inv(pre);
    result = dec ? inv : aff_fwd(inv);
  end

endmodule

module sbox_share_sched #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_StReq,
  input  logic [127:0] i_StData,
  input  logic         i_fDec,
  output logic         o_StDone,
  output logic [127:0] o_StData,
  input  logic         i_KeyReq,
  input  logic [31:0]  i_KeyData,
  output logic         o_KeyDone,
  output logic [31:0]  o_KeyData,
  output logic         o_Busy
);

  typedef enum logic [2:0] {IDLE, ST, KEY, ST_DONE, KEY_DONE} state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] st_buf;
  logic [31:0]  key_buf;
  logic         dec_q;
  logic         last_key;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic         sb_dec;

  always_comb begin
    sb_in  = st_buf[127:96];
    sb_dec = 1'b0;
    if (state == KEY) begin
      sb_in = key_buf;
    end else begin
      case (cnt)
        2'd0: sb_in = st_buf[127:96];
        2'd1: sb_in = st_buf[95:64];
        2'd2: sb_in = st_buf[63:32];
        default: sb_in = st_buf[31:0];
      endcase
      sb_dec = (state == ST) && dec_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox_lookup u_sbox (
      .data  (sb_in[31-8*i -: 8]),
      .dec   (sb_dec),
      .result(sb_out[31-8*i -: 8])
    );
  end

  // last_key records who finished last; the other side wins a contested grant.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      st_buf    <= '0;
      key_buf   <= '0;
      dec_q     <= 1'b0;
      last_key  <= ~KEY_FIRST;
      o_StDone  <= 1'b0;
      o_KeyDone <= 1'b0;
      o_StData  <= '0;
      o_KeyData <= '0;
      o_Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_StReq && (!i_KeyReq || last_key)) begin
            st_buf <= i_StData;
            dec_q  <= i_fDec;
            cnt    <= 2'd0;
            state  <= ST;
            o_Busy <= 1'b1;
          end else if (i_KeyReq) begin
            key_buf <= i_KeyData;
            state   <= KEY;
            o_Busy  <= 1'b1;
          end
        end
        ST: begin
          case (cnt)
            2'd0: o_StData[127:96] <= sb_out;
            2'd1: o_StData[95:64]  <= sb_out;
            2'd2: o_StData[63:32]  <= sb_out;
            default: o_StData[31:0] <= sb_out;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state    <= ST_DONE;
            o_StDone <= 1'b1;
            last_key <= 1'b0;
          end
        end
        KEY: begin
          o_KeyData <= sb_out;
          state     <= KEY_DONE;
          o_KeyDone <= 1'b1;
          last_key  <= 1'b1;
        end
        ST_DONE, KEY_DONE: begin
          o_StDone  <= 1'b0;
          o_KeyDone <= 1'b0;
          o_Busy    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
